// File: rtl/button_debouncer_pkg.sv
// rtl/button_debouncer_pkg.sv - shared state encodings, polarity constants and sizing helper
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        IDLE_REL  = 2'd0,
        PRESS_CHK = 2'd1,
        PRESSED   = 2'd2,
        REL_CHK   = 2'd3
    } btn_state_e;

    localparam logic BTN_PRESSED  = 1'b0;
    localparam logic BTN_RELEASED = 1'b1;

    // Qualification counter width; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - parameterised async-reset flop chain for asynchronous pad inputs
module sync_chain #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchronise, debounce and glitch-count one active-low pushbutton
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_raw,
    output logic                btn_clean,
    output logic                stable,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                btn_sync;
    btn_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                clean_q, clean_d;
    logic [GLITCH_W-1:0] glitch_q, glitch_d;
    logic                glitch_hit;

    sync_chain #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (BTN_RELEASED)
    ) u_sync (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (btn_raw),
        .q_o    (btn_sync)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        glitch_hit = 1'b0;

        case (state_q)
            IDLE_REL: begin
                if (btn_sync == BTN_PRESSED) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                // A reverting sample wins even on the final qualifying edge.
                if (btn_sync == BTN_RELEASED) begin
                    state_d    = IDLE_REL;
                    cnt_d      = '0;
                    glitch_hit = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (btn_sync == BTN_RELEASED) begin
                    state_d = REL_CHK;
                    cnt_d   = '0;
                end
            end
            REL_CHK: begin
                if (btn_sync == BTN_PRESSED) begin
                    state_d    = PRESSED;
                    cnt_d      = '0;
                    glitch_hit = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE_REL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE_REL;
                cnt_d   = '0;
            end
        endcase

        // The clean level follows the state being entered so both flops move together.
        clean_d = ((state_d == PRESSED) || (state_d == REL_CHK)) ? BTN_PRESSED : BTN_RELEASED;

        if (glitch_hit && (glitch_q != {GLITCH_W{1'b1}})) begin
            glitch_d = glitch_q + GLITCH_W'(1);
        end else begin
            glitch_d = glitch_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE_REL;
            cnt_q    <= '0;
            clean_q  <= BTN_RELEASED;
            glitch_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            clean_q  <= clean_d;
            glitch_q <= glitch_d;
        end
    end

    assign btn_clean  = clean_q;
    assign stable     = (state_q == IDLE_REL) || (state_q == PRESSED);
    assign glitch_cnt = glitch_q;

endmodule
